// File: rtl/cu_sel_ctrl_pkg.sv
// Shared types and helpers for the chip-select control unit: FSM state
// encoding and the select-code to one-hot decode.
package cu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    RESP
  } cu_state_t;

  // Widest target count the decode helper supports; callers size-cast down.
  localparam int unsigned MAX_TGT = 64;

  typedef logic [MAX_TGT-1:0] onehot_t;

  function automatic onehot_t sel_to_onehot(input int unsigned sel);
    return onehot_t'(1) << sel;
  endfunction

endpackage

// File: rtl/cu_sel_ctrl_if.sv
// Request/response handshake between the sequencer (master) and the
// chip-select control unit (slave).
interface cu_sel_ctrl_if #(
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  req_sel;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              done;

  modport master (
    output req_valid, req_sel, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, done
  );

  modport slave (
    input  req_valid, req_sel, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, done
  );

endinterface

// File: rtl/cu_sel_ctrl_shifter.sv
// Parallel-load shift register with bit counter; shifts MSB out and the
// serial input into the LSB, so one register serves both writes and reads.
module cu_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              cnt_load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  input  logic              ser_in,
  output logic              msb,
  output logic [DATA_W-1:0] q,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking (<=) for every flop so all registers update from
  // their pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      if (load) begin
        q <= din;
      end else if (shift) begin
        q <= {q[DATA_W-2:0], ser_in};
      end

      if (cnt_load) begin
        cnt <= CNT_W'(DATA_W - 1);
      end else if (shift) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign msb  = q[DATA_W-1];
  assign last = (cnt == '0);

endmodule

// File: rtl/cu_sel_ctrl.sv
// Chip-select control unit: accepts one request, enables one target,
// moves one word bit-serially, then returns a response with a done pulse.
module cu_sel_ctrl
  import cu_pkg::*;
#(
  parameter int NUM_TGT = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = (NUM_TGT > 2) ? $clog2(NUM_TGT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  cu_sel_ctrl_if.slave       bus,
  output logic [NUM_TGT-1:0] tgt_en,
  output logic               tgt_we,
  output logic [ADDR_W-1:0]  tgt_addr,
  output logic               ser_out,
  input  logic               ser_in
);

  cu_state_t         state_q, state_d;
  logic [SEL_W-1:0]  sel_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              done_q;
  logic              accept;
  logic              sel_ok;
  logic              sh_msb;
  logic              sh_last;
  logic [DATA_W-1:0] sh_q;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign sel_ok = (32'(bus.req_sel) < NUM_TGT);

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = sel_ok ? SETUP : RESP;
      SETUP: state_d = SHIFT;
      SHIFT: if (sh_last) state_d = RESP;
      RESP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Pulse only on entry to RESP, never while it stalls.
      done_q  <= (state_d == RESP) && (state_q != RESP);
      if (accept) begin
        sel_q  <= bus.req_sel;
        wr_q   <= bus.req_wr;
        addr_q <= bus.req_addr;
        err_q  <= !sel_ok;
      end
    end
  end

  cu_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .cnt_load (state_q == SETUP),
    .shift    (state_q == SHIFT),
    .din      (bus.req_wdata),
    .ser_in   (ser_in),
    .msb      (sh_msb),
    .q        (sh_q),
    .last     (sh_last)
  );

  // Outputs decode from registered state only, so tgt_en cannot overlap
  // between transactions and drops as soon as reset hits.
  assign tgt_en        = ((state_q == SETUP) || (state_q == SHIFT))
                         ? NUM_TGT'(sel_to_onehot(32'(sel_q))) : '0;
  assign tgt_we        = (state_q == SHIFT) && wr_q;
  assign tgt_addr      = addr_q;
  assign ser_out       = tgt_we && sh_msb;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_rdata = ((state_q == RESP) && !wr_q && !err_q) ? sh_q : '0;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_cu_sel_ctrl.sv
// Self-checking bench: directed cases on default and 3-target instances, plus
// random traffic on a 16-bit/8-target instance against a behavioural model.
module tb_cu_sel_ctrl;

  localparam int DC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected target-side view k cycles after the accept cycle.
  typedef struct packed {
    logic [7:0] en;
    logic       we;
    logic       ser;
    logic       rv;
    logic       dn;
  } exp_t;

  function automatic exp_t model_at(input int d, input int k, input int sel,
                                    input logic wr, input logic [31:0] wdata);
    exp_t e;
    e = '0;
    if (k >= 1 && k <= d + 1) e.en = 8'(1 << sel);
    if (k >= 2 && k <= d + 1) begin
      e.we  = wr;
      e.ser = wr & wdata[d + 1 - k];
    end
    if (k >= d + 2) begin
      e.rv = 1'b1;
      e.dn = (k == d + 2);
    end
    return e;
  endfunction

  // ---------------- DUT A: default parameters ----------------
  cu_sel_ctrl_if #(.SEL_W(2), .ADDR_W(3), .DATA_W(8)) a_if ();
  logic [3:0] a_tgt_en;
  logic       a_tgt_we;
  logic [2:0] a_tgt_addr;
  logic       a_ser_out;
  logic       a_ser_in;

  cu_sel_ctrl #(.NUM_TGT(4), .ADDR_W(3), .DATA_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .tgt_en(a_tgt_en), .tgt_we(a_tgt_we),
    .tgt_addr(a_tgt_addr), .ser_out(a_ser_out), .ser_in(a_ser_in)
  );

  // ---------------- DUT B: three targets, out-of-range select ----------------
  cu_sel_ctrl_if #(.SEL_W(2), .ADDR_W(3), .DATA_W(8)) b_if ();
  logic [2:0] b_tgt_en;
  logic       b_tgt_we;
  logic [2:0] b_tgt_addr;
  logic       b_ser_out;
  logic       b_ser_in;

  cu_sel_ctrl #(.NUM_TGT(3), .ADDR_W(3), .DATA_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .tgt_en(b_tgt_en), .tgt_we(b_tgt_we),
    .tgt_addr(b_tgt_addr), .ser_out(b_ser_out), .ser_in(b_ser_in)
  );

  // ---------------- DUT C: 16-bit words, eight targets ----------------
  cu_sel_ctrl_if #(.SEL_W(3), .ADDR_W(3), .DATA_W(DC)) c_if ();
  logic [7:0] c_tgt_en;
  logic       c_tgt_we;
  logic [2:0] c_tgt_addr;
  logic       c_ser_out;
  logic       c_ser_in;

  cu_sel_ctrl #(.NUM_TGT(8), .ADDR_W(3), .DATA_W(DC)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if.slave), .tgt_en(c_tgt_en), .tgt_we(c_tgt_we),
    .tgt_addr(c_tgt_addr), .ser_out(c_ser_out), .ser_in(c_ser_in)
  );

  // Target storage as seen by the bus (tmem) and as intended by requests (ref_mem).
  logic [DC-1:0] tmem    [8][8];
  logic [DC-1:0] ref_mem [8][8];
  int            t_cnt = 0;
  int            t_idx = 0;
  logic [DC-1:0] t_wsh = '0;

  always @(negedge clk) begin
    if (c_tgt_en != '0) begin
      t_cnt++;
      for (int i = 0; i < 8; i++) if (c_tgt_en[i]) t_idx = i;
      if (t_cnt >= 2 && t_cnt <= DC + 1) begin
        c_ser_in = tmem[t_idx][c_tgt_addr][DC + 1 - t_cnt];
        if (c_tgt_we) begin
          t_wsh = {t_wsh[DC-2:0], c_ser_out};
          if (t_cnt == DC + 1) tmem[t_idx][c_tgt_addr] = t_wsh;
        end
      end
    end else begin
      t_cnt = 0;
    end
  end

  // Reference model and per-cycle compare for DUT C.
  logic          c_phase = 1'b0;
  logic          c_act = 1'b0;
  int            c_t0 = 0;
  int            c_done = 0;
  logic [2:0]    c_sel = '0;
  logic          c_wr = 1'b0;
  logic [2:0]    c_addr = '0;
  logic [DC-1:0] c_wdata = '0;

  always @(negedge clk) begin
    if (c_phase) begin
      exp_t e;
      int   k;
      k = c_act ? (cyc - c_t0) : 0;
      e = c_act ? model_at(DC, k, int'(c_sel), c_wr, 32'(c_wdata)) : exp_t'(0);
      check("c_onehot0", 32'($onehot0(c_tgt_en)), 1);
      check("c_req_ready", c_if.req_ready, !c_act);
      check("c_tgt_en", c_tgt_en, e.en);
      check("c_tgt_we", c_tgt_we, e.we);
      check("c_ser_out", c_ser_out, e.ser);
      check("c_rsp_valid", c_if.rsp_valid, e.rv);
      check("c_done", c_if.done, e.dn);
      if (e.en != '0) check("c_tgt_addr", c_tgt_addr, c_addr);
      if (e.rv) begin
        check("c_rsp_err", c_if.rsp_err, 0);
        check("c_rsp_rdata", c_if.rsp_rdata, c_wr ? '0 : ref_mem[c_sel][c_addr]);
      end
      if (c_act && e.rv && c_if.rsp_ready) begin
        c_act = 1'b0;
        c_done++;
        if (c_wr) ref_mem[c_sel][c_addr] = c_wdata;
      end else if (!c_act && c_if.req_valid) begin
        c_act   = 1'b1;
        c_t0    = cyc;
        c_sel   = c_if.req_sel;
        c_wr    = c_if.req_wr;
        c_addr  = c_if.req_addr;
        c_wdata = c_if.req_wdata;
      end
    end
  end

  // One transaction on DUT A; entered and left just after a rising edge.
  task automatic a_txn(input logic [1:0] sel, input logic wr, input logic [2:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rbits,
                       input int stall, input int rst_at);
    logic [7:0] exp_rd;
    exp_rd = wr ? 8'h00 : rbits;
    a_ser_in        = 1'b0;
    a_if.req_valid  = 1'b1;
    a_if.req_sel    = sel;
    a_if.req_wr     = wr;
    a_if.req_addr   = addr;
    a_if.req_wdata  = wdata;
    a_if.rsp_ready  = (stall == 0);
    @(negedge clk);
    check("a_req_ready_idle", a_if.req_ready, 1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        a_if.req_valid = 1'b0;
        a_if.req_sel   = ~sel;
        a_if.req_wr    = ~wr;
        a_if.req_addr  = ~addr;
        a_if.req_wdata = ~wdata;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("a_rst_outs", {a_tgt_en, a_tgt_we, a_tgt_addr, a_ser_out, a_if.rsp_valid,
                             a_if.rsp_err, a_if.done, a_if.rsp_rdata}, 0);
        check("a_rst_ready", a_if.req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        a_ser_in = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      check("a_tgt_en", a_tgt_en, 4'b0001 << sel);
      check("a_tgt_addr", a_tgt_addr, addr);
      check("a_req_ready_busy", a_if.req_ready, 0);
      if (k >= 2) begin
        check("a_tgt_we", a_tgt_we, wr);
        check("a_ser_out", a_ser_out, wr ? wdata[9 - k] : 1'b0);
        a_ser_in = rbits[9 - k];
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("a_rsp_valid", a_if.rsp_valid, 1);
    check("a_done_first", a_if.done, 1);
    check("a_rsp_err", a_if.rsp_err, 0);
    check("a_rsp_rdata", a_if.rsp_rdata, exp_rd);
    check("a_resp_tgt", {a_tgt_en, a_tgt_we, a_ser_out, a_if.req_ready}, 0);
    for (int s = 1; s <= stall; s++) begin
      @(posedge clk); #1;
      if (s == stall) a_if.rsp_ready = 1'b1;
      @(negedge clk);
      check("a_stall_valid", a_if.rsp_valid, 1);
      check("a_stall_done", a_if.done, 0);
      check("a_stall_rdata", a_if.rsp_rdata, exp_rd);
      check("a_stall_ready", a_if.req_ready, 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("a_back_idle", {a_if.req_ready, a_if.rsp_valid, a_if.done}, 3'b100);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    a_if.req_valid = 1'b0; a_if.req_sel = '0; a_if.req_wr = 1'b0;
    a_if.req_addr = '0; a_if.req_wdata = '0; a_if.rsp_ready = 1'b1; a_ser_in = 1'b0;
    b_if.req_valid = 1'b0; b_if.req_sel = '0; b_if.req_wr = 1'b0;
    b_if.req_addr = '0; b_if.req_wdata = '0; b_if.rsp_ready = 1'b1; b_ser_in = 1'b0;
    c_if.req_valid = 1'b0; c_if.req_sel = '0; c_if.req_wr = 1'b0;
    c_if.req_addr = '0; c_if.req_wdata = '0; c_if.rsp_ready = 1'b1; c_ser_in = 1'b0;

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        tmem[i][j]    = DC'($urandom);
        ref_mem[i][j] = tmem[i][j];
      end

    // Pin the model against hand-derived points of the 8'hA5 write timeline.
    check("model_k0_en", model_at(8, 0, 0, 1'b1, 32'hA5).en, 0);
    check("model_k1_en", model_at(8, 1, 0, 1'b1, 32'hA5).en, 1);
    check("model_k2_ser", model_at(8, 2, 0, 1'b1, 32'hA5).ser, 1);
    check("model_k3_ser", model_at(8, 3, 0, 1'b1, 32'hA5).ser, 0);
    check("model_k7_ser", model_at(8, 7, 0, 1'b1, 32'hA5).ser, 1);
    check("model_k10_done", model_at(8, 10, 0, 1'b1, 32'hA5).dn, 1);
    check("model_k11_done", model_at(8, 11, 0, 1'b1, 32'hA5).dn, 0);

    #2;
    check("rst_a_outs", {a_tgt_en, a_tgt_we, a_tgt_addr, a_ser_out, a_if.rsp_valid,
                         a_if.rsp_err, a_if.done, a_if.rsp_rdata}, 0);
    check("rst_a_ready", a_if.req_ready, 1);
    check("rst_c_outs", {c_tgt_en, c_tgt_we, c_if.rsp_valid, c_if.done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    a_txn(2'd0, 1'b1, 3'd5, 8'hA5, 8'h00, 0, 0);
    a_txn(2'd1, 1'b0, 3'd2, 8'h33, 8'h6C, 0, 0);
    a_txn(2'd3, 1'b0, 3'd1, 8'h00, 8'h9E, 5, 0);
    a_txn(2'd2, 1'b1, 3'd4, 8'h3C, 8'h00, 3, 0);
    a_txn(2'd1, 1'b0, 3'd3, 8'h00, 8'h6C, 0, 4);
    a_txn(2'd2, 1'b1, 3'd7, 8'hFF, 8'h00, 0, 0);

    // Out-of-range select on the three-target instance, then a valid one.
    b_if.req_valid = 1'b1; b_if.req_sel = 2'b11; b_if.req_wr = 1'b0;
    b_if.req_addr = 3'd6; b_if.req_wdata = 8'h5A; b_if.rsp_ready = 1'b1;
    @(negedge clk);
    check("b_req_ready", b_if.req_ready, 1);
    @(posedge clk); #1;
    b_if.req_valid = 1'b0;
    @(negedge clk);
    check("b_err_tgt_en", b_tgt_en, 0);
    check("b_err_rsp", {b_if.rsp_valid, b_if.rsp_err, b_if.done}, 3'b111);
    check("b_err_rdata", b_if.rsp_rdata, 0);
    @(posedge clk); #1;
    b_if.req_valid = 1'b1; b_if.req_sel = 2'd2;
    @(negedge clk);
    check("b_next_accept", {b_if.req_ready, b_if.rsp_valid}, 2'b10);
    @(posedge clk); #1;
    b_if.req_valid = 1'b0;
    @(negedge clk);
    check("b_sel2_tgt_en", b_tgt_en, 3'b100);
    check("b_sel2_err", {b_if.rsp_valid, b_if.rsp_err}, 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("b_sel2_idle", b_if.req_ready, 1);
    @(posedge clk); #1;

    // Random traffic on the 16-bit, eight-target instance.
    c_phase = 1'b1;
    for (int guard = 0; guard < 20000 && c_done < 100; guard++) begin
      c_if.req_valid = ($urandom_range(0, 4) != 0);
      c_if.req_sel   = 3'($urandom);
      c_if.req_wr    = 1'($urandom);
      c_if.req_addr  = 3'($urandom_range(0, 3));
      c_if.req_wdata = DC'($urandom);
      c_if.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    c_if.req_valid = 1'b0;
    c_if.rsp_ready = 1'b1;
    repeat (DC + 4) @(posedge clk);
    @(negedge clk);
    c_phase = 1'b0;
    check("c_txn_count", c_done, 100);
    check("c_final_idle", c_if.req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
